// File: rtl/rank_change_logger.sv
// Purpose: logs every cycle where din differs from its previous sample, as {value, 16-bit cycle stamp}, into a FWFT FIFO.
// Latency: an event in cycle N is visible at the FIFO head in cycle N+1 when the FIFO was empty.
// Backpressure: dout_valid/dout_ready handshake; events arriving while full with no pop are dropped and set a sticky overflow.
// Optional: define RANK_CHANGE_LOGGER_DROP_CNT_EN to add an 8-bit saturating drop_cnt output.
module rank_change_logger #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [15:0]              dout_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef RANK_CHANGE_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] prev;
  logic [15:0]           cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem_dat  [DEPTH];
  logic [15:0]           mem_time [DEPTH];

  logic evt;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event detection and FIFO push/pop/drop decisions for the current cycle.
  always_comb begin
    evt  = (din != prev);
    full = (level == FULL_LVL);
    pop  = dout_valid && dout_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    push = evt && (!full || pop);
    drop = evt && full && !pop;
  end

  // Head presentation: zeros while empty so the consumer never sees stale entries.
  always_comb begin
    dout_valid = (level != '0);
    dout       = dout_valid ? mem_dat[rd_ptr]  : '0;
    dout_time  = dout_valid ? mem_time[rd_ptr] : '0;
  end

  // Storage array; not reset, entries are only meaningful through level.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_dat[wr_ptr]  <= din;
      mem_time[wr_ptr] <= cnt;
    end
  end

  // Previous-sample register, cycle counter, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= din;
      cnt  <= cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef RANK_CHANGE_LOGGER_DROP_CNT_EN
  // Saturating count of dropped events.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
